// File: rtl/drive_sequencer_pkg.sv
// drive_seq_pkg: shared definitions for the drive sequencer.
//   - FSM state encoding (IDLE=0 .. FAULT=4)
//   - command opcodes (rx_data[7:6]) and system command bytes
//   - steering servo limits and a clamp helper used by the trim option
package drive_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPINUP = 3'd1,
        RUN    = 3'd2,
        STOP   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [1:0] OP_SYS    = 2'b00;
    localparam logic [1:0] OP_THRUST = 2'b01;
    localparam logic [1:0] OP_STEER  = 2'b10;
    localparam logic [1:0] OP_TRIM   = 2'b11;

    localparam logic [7:0] CMD_ARM    = 8'h01;
    localparam logic [7:0] CMD_DISARM = 8'h02;
    localparam logic [7:0] CMD_ESTOP  = 8'h03;

    localparam logic [9:0] STEER_MIN    = 10'd51;
    localparam logic [9:0] STEER_MAX    = 10'd102;
    localparam logic [9:0] STEER_CENTER = 10'd77;

    // Clamp a signed steering sum into the servo's legal window.
    function automatic logic [9:0] steer_clamp(input logic signed [10:0] v);
        if (v < 11'sd51)
            return STEER_MIN;
        else if (v > 11'sd102)
            return STEER_MAX;
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// drive_sequencer_if: command byte input and actuator outputs of the sequencer.
//   master : drives rx_data/rx_valid (byte receiver side), observes outputs
//   slave  : the sequencer itself
//   rx_data[8], rx_valid, lift/thrust/steer_duty[10], state[3], led, cmd_err
interface drive_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] lift_duty;
    logic [9:0] thrust_duty;
    logic [9:0] steer_duty;
    logic [2:0] state;
    logic       led;
    logic       cmd_err;

    modport master (
        output rx_data, rx_valid,
        input  lift_duty, thrust_duty, steer_duty, state, led, cmd_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output lift_duty, thrust_duty, steer_duty, state, led, cmd_err
    );
endinterface

// File: rtl/drive_sequencer_slew.sv
// slew_limiter: registered duty that moves toward target by at most `step`
// on each tick, landing exactly on target when within one step.
//   clk, rst_n (async low), tick, clr (sync force to 0), target[10], step[10]
//   cur[10] : registered duty output
module slew_limiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clr,
    input  logic [9:0] target,
    input  logic [9:0] step,
    output logic [9:0] cur
);
    // Differences are taken in the non-negative direction only, so the
    // +/- step paths cannot wrap past 0 or 1023.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur <= '0;
        else if (clr)
            cur <= '0;
        else if (tick) begin
            if (target >= cur)
                cur <= ((target - cur) <= step) ? target : cur + step;
            else
                cur <= ((cur - target) <= step) ? target : cur - step;
        end
    end
endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: decodes one-byte link commands and sequences the lift fan,
// thrust motor and steering servo through IDLE/SPINUP/RUN/STOP/FAULT.
//   clk, rst_n (async low)
//   bus (drive_sequencer_if.slave): rx_data/rx_valid in; lift/thrust/steer
//   duty (x/1024), state, led, cmd_err out.
// Optional build macro STEER_TRIM_EN: opcode 11 becomes a signed steering
// trim added to every steering output (clamped to 51..102).
module drive_sequencer
    import drive_seq_pkg::*;
#(
    parameter int TICK_CYCLES   = 100000,
    parameter int RAMP_STEP     = 8,
    parameter int LIFT_DUTY     = 768,
    parameter int TIMEOUT_TICKS = 500
) (
    input  logic clk,
    input  logic rst_n,
    drive_sequencer_if.slave bus
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);

    state_t      state, state_n;
    logic [PW-1:0] pre_cnt;
    logic [WW-1:0] wd_cnt;
    logic        tick, wd_exp, active;
    logic [9:0]  lift_cur, thrust_cur, lift_tgt, thrust_tgt, steer_base;
    logic        cmd_vld, is_sys, c_arm, c_disarm, c_estop;
    logic        c_thrust, c_steer, c_trim, bad_cmd, cmd_err_q;
    logic [5:0]  lvl;

    assign lvl     = bus.rx_data[5:0];
    assign cmd_vld = bus.rx_valid && (bus.rx_data != 8'h00);
    assign is_sys  = cmd_vld && (bus.rx_data[7:6] == OP_SYS);
    assign c_arm   = is_sys && (bus.rx_data == CMD_ARM);
    assign c_disarm= is_sys && (bus.rx_data == CMD_DISARM);
    assign c_estop = is_sys && (bus.rx_data == CMD_ESTOP);
    assign c_thrust= cmd_vld && (bus.rx_data[7:6] == OP_THRUST);
    assign c_steer = cmd_vld && (bus.rx_data[7:6] == OP_STEER);
    assign c_trim  = cmd_vld && (bus.rx_data[7:6] == OP_TRIM);
`ifdef STEER_TRIM_EN
    assign bad_cmd = is_sys && !(c_arm || c_disarm || c_estop);
`else
    assign bad_cmd = (is_sys && !(c_arm || c_disarm || c_estop)) || c_trim;
`endif

    // Control tick prescaler.
    assign tick = (pre_cnt == PW'(TICK_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end

    // Link watchdog: any received byte (even 0x00) restarts it, and a byte
    // arriving on the expiring tick still wins.
    assign active = (state == SPINUP) || (state == RUN);
    assign wd_exp = active && tick && !bus.rx_valid &&
                    (wd_cnt == WW'(TIMEOUT_TICKS - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wd_cnt <= '0;
        else if (bus.rx_valid || !active) wd_cnt <= '0;
        else if (tick)                   wd_cnt <= wd_cnt + WW'(1);
    end

    always_comb begin
        state_n = state;
        if (c_estop)
            state_n = FAULT;
        else begin
            case (state)
                IDLE:   if (c_arm) state_n = SPINUP;
                SPINUP: if (c_disarm || wd_exp)       state_n = STOP;
                        else if (lift_cur == 10'(LIFT_DUTY)) state_n = RUN;
                RUN:    if (c_disarm || wd_exp) state_n = STOP;
                STOP:   if (lift_cur == '0 && thrust_cur == '0) state_n = IDLE;
                FAULT:  if (c_disarm) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            thrust_tgt <= '0;
            steer_base <= STEER_CENTER;
            cmd_err_q  <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_err_q <= bad_cmd;
            // Leaving RUN (or never being there) zeroes the thrust target.
            if (state_n != RUN)
                thrust_tgt <= '0;
            else if (c_thrust && state == RUN)
                thrust_tgt <= {lvl, 4'b0000};
            if (state_n == FAULT)
                steer_base <= STEER_CENTER;
            else if (c_steer)
                steer_base <= STEER_MIN +
                    ((lvl > 6'd51) ? (STEER_MAX - STEER_MIN) : {4'd0, lvl});
        end
    end

    assign lift_tgt = active ? 10'(LIFT_DUTY) : 10'd0;

    // ESTOP zeroes the duties on the very next edge, bypassing the ramp.
    slew_limiter u_lift (
        .clk(clk), .rst_n(rst_n), .tick(tick), .clr(c_estop || state == FAULT),
        .target(lift_tgt), .step(10'(RAMP_STEP)), .cur(lift_cur)
    );
    slew_limiter u_thrust (
        .clk(clk), .rst_n(rst_n), .tick(tick), .clr(c_estop || state == FAULT),
        .target(thrust_tgt), .step(10'(RAMP_STEP)), .cur(thrust_cur)
    );

`ifdef STEER_TRIM_EN
    logic signed [5:0] trim;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      trim <= '0;
        else if (c_trim) trim <= lvl;
    end
    assign bus.steer_duty = steer_clamp($signed({1'b0, steer_base}) +
                                        $signed({{5{trim[5]}}, trim}));
`else
    assign bus.steer_duty = steer_base;
`endif

    assign bus.lift_duty   = lift_cur;
    assign bus.thrust_duty = thrust_cur;
    assign bus.state       = state;
    assign bus.led         = active;
    assign bus.cmd_err     = cmd_err_q;
endmodule

// File: tb/tb_drive_sequencer.sv
module tb_drive_sequencer;
    import drive_seq_pkg::*;

    localparam int S_LIFT = 0, S_THR = 1, S_STEER = 2, S_STATE = 3, S_LED = 4, S_ERR = 5;

    typedef struct {
        int    due;
        int    sig;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    drive_sequencer_if bus();

    drive_sequencer #(
        .TICK_CYCLES(4), .RAMP_STEP(64), .LIFT_DUTY(768), .TIMEOUT_TICKS(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input int sig);
        case (sig)
            S_LIFT:  return int'(bus.lift_duty);
            S_THR:   return int'(bus.thrust_duty);
            S_STEER: return int'(bus.steer_duty);
            S_STATE: return int'(bus.state);
            S_LED:   return int'(bus.led);
            default: return int'(bus.cmd_err);
        endcase
    endfunction

    task automatic chk(input int rel, input int sig, input int val, input string name);
        exp_t e;
        e.due = base + rel; e.sig = sig; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic at(input int r);
        while (cyc - base < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int r, input logic [7:0] b);
        at(r);
        bus.rx_data = b; bus.rx_valid = 1'b1;
        at(r + 1);
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    endtask

    always @(negedge clk) begin : mon
        int act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                act = sample(sb[i].sig);
                n_chk++;
                if (act != sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                             sb[i].name, cyc - base, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        chk(1, S_STATE, 0, "rst_state"); chk(1, S_LIFT, 0, "rst_lift");
        chk(1, S_THR, 0, "rst_thrust");  chk(1, S_STEER, 77, "rst_steer");
        chk(1, S_LED, 0, "rst_led");     chk(1, S_ERR, 0, "rst_cmd_err");
        @(posedge clk); #1;
        rst_n = 1'b1; base = cyc;

        chk(3, S_STATE, 1, "arm_spinup"); chk(3, S_LED, 1, "spinup_led");
        chk(3, S_LIFT, 0, "lift_t0");     chk(4, S_LIFT, 64, "lift_t1");
        chk(8, S_LIFT, 128, "lift_t2");   chk(44, S_LIFT, 704, "lift_t11");
        chk(48, S_LIFT, 768, "lift_t12"); chk(48, S_STATE, 1, "still_spinup");
        chk(49, S_STATE, 2, "run");       chk(49, S_THR, 0, "spinup_thr0");
        send(2, CMD_ARM);

        chk(51, S_THR, 0, "thr_up0");     chk(52, S_THR, 64, "thr_up1");
        chk(100, S_LIFT, 768, "lift_held"); chk(100, S_LED, 1, "run_led");
        chk(108, S_THR, 960, "thr_up15"); chk(112, S_THR, 1008, "thr_up16");
        chk(115, S_THR, 1008, "thr_old_tgt"); chk(116, S_THR, 944, "thr_dn1");
        chk(172, S_THR, 48, "thr_dn15");  chk(176, S_THR, 0, "thr_dn16");
        send(50, 8'h7F);
        send(114, 8'h40);

        chk(179, S_STEER, 102, "steer_max"); chk(181, S_STEER, 51, "steer_min");
        chk(183, S_STEER, 77, "steer_mid");  chk(184, S_ERR, 0, "err_idle");
`ifdef STEER_TRIM_EN
        chk(185, S_ERR, 0, "trim_no_err");   chk(185, S_STEER, 82, "trim_plus5");
        chk(187, S_STEER, 77, "trim_zero");
`else
        chk(185, S_ERR, 1, "op11_err");      chk(185, S_STEER, 77, "op11_steer");
        chk(187, S_ERR, 1, "op11_err2");
`endif
        chk(186, S_ERR, 0, "err_one_cycle");
        chk(189, S_ERR, 1, "sys_bad_err");   chk(189, S_STATE, 2, "sys_bad_state");
        send(178, 8'hBF); send(180, 8'h80); send(182, 8'h9A);
        send(184, 8'hC5); send(186, 8'hC0); send(188, 8'h04);

        chk(252, S_THR, 1008, "thr_full");  chk(255, S_STEER, 102, "steer_pre_estop");
        chk(257, S_STATE, 4, "estop_fault"); chk(257, S_LIFT, 0, "estop_lift");
        chk(257, S_THR, 0, "estop_thr");    chk(257, S_STEER, 77, "estop_steer");
        chk(257, S_LED, 0, "estop_led");    chk(262, S_STATE, 4, "fault_arm_ign");
        chk(264, S_STEER, 77, "fault_steer_ign"); chk(265, S_LIFT, 0, "fault_lift");
        chk(266, S_THR, 0, "fault_thr_ign"); chk(267, S_STATE, 0, "disarm_idle");
        send(190, 8'h7F); send(254, 8'hBF); send(256, CMD_ESTOP);
        send(260, CMD_ARM); send(262, 8'h80); send(264, 8'h7F); send(266, CMD_DISARM);

        chk(317, S_STATE, 2, "wd_run");     chk(395, S_STATE, 2, "wd_pre");
        chk(396, S_STATE, 3, "wd_stop");    chk(396, S_LED, 0, "stop_led");
        chk(400, S_LIFT, 704, "stop_ramp1"); chk(444, S_LIFT, 0, "stop_ramp12");
        chk(444, S_STATE, 3, "stop_hold");  chk(445, S_STATE, 0, "stop_idle");
        send(270, CMD_ARM); send(318, 8'h00);

        chk(497, S_STATE, 2, "run2");       chk(603, S_STATE, 2, "wd_null_kept");
        chk(605, S_STATE, 2, "wd_same_cyc"); chk(610, S_STATE, 2, "wd_same_cyc2");
        send(450, CMD_ARM); send(524, 8'h00); send(603, 8'h00);

        chk(613, S_STATE, 3, "disarm_stop"); chk(622, S_STATE, 3, "stop_arm_ign");
        chk(661, S_STATE, 0, "idle3");       chk(713, S_STATE, 2, "run3");
        chk(720, S_THR, 0, "idle_thr_ign");  chk(720, S_LIFT, 768, "run3_lift");
        send(612, CMD_DISARM); send(620, CMD_ARM); send(664, 8'h7F); send(666, CMD_ARM);

        chk(769, S_STATE, 0, "idle4");      chk(775, S_STEER, 51, "steer_pre_rst");
        chk(785, S_LIFT, 192, "spin_lift"); chk(785, S_STATE, 1, "spin_state");
        send(722, CMD_DISARM); send(772, CMD_ARM); send(774, 8'h80);
        at(786);
        rst_n = 1'b0;
        chk(786, S_STATE, 0, "mid_rst_state"); chk(786, S_LIFT, 0, "mid_rst_lift");
        chk(786, S_THR, 0, "mid_rst_thr");     chk(786, S_STEER, 77, "mid_rst_steer");
        chk(786, S_LED, 0, "mid_rst_led");     chk(786, S_ERR, 0, "mid_rst_err");
        #1;
        n_chk++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL async_rst_state: got %0d", bus.state);
        end
        n_chk++;
        if (bus.lift_duty !== 10'd0) begin
            n_fail++; $display("FAIL async_rst_lift: got %0d", bus.lift_duty);
        end
        n_chk++;
        if (bus.thrust_duty !== 10'd0) begin
            n_fail++; $display("FAIL async_rst_thr: got %0d", bus.thrust_duty);
        end
        n_chk++;
        if (bus.steer_duty !== 10'd77) begin
            n_fail++; $display("FAIL async_rst_steer: got %0d", bus.steer_duty);
        end
        n_chk++;
        if (bus.led !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_led: got %0d", bus.led);
        end
        at(790);
        rst_n = 1'b1;
        at(795);

        foreach (sb[i]) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: never sampled, expected %0d", sb[i].name, sb[i].val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
- Command sequencer between the Bluetooth byte receiver and the three PWM actuator channels: lift fan, thrust motor and steering servo.
- Decodes one-byte commands and runs an arm / spin-up / run / stop state machine.
- Slew-limits the lift and thrust duties, and drops to a safe state on link-loss timeout or emergency stop.
- Outputs are 10-bit duty words (x/1024) that feed the PWM generators directly.

Parameters:
- TICK_CYCLES, 100000: clk cycles per control tick (1 ms at 100 MHz).
- RAMP_STEP, 8: maximum duty change per tick on lift and thrust.
- LIFT_DUTY, 768: lift duty held in SPINUP end and RUN.
- TIMEOUT_TICKS, 500: ticks without rx_valid before the watchdog forces STOP.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- rx_data  in  8  received command byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- lift_duty  out  10  lift fan duty.
- thrust_duty  out  10  thrust motor duty.
- steer_duty  out  10  servo duty (50 Hz channel).
- state  out  3  current FSM state.
- led  out  1  high in SPINUP or RUN.
- cmd_err  out  1  one-cycle pulse on an invalid command.

Behaviour:
- Reset: one clk; asynchronous, active-low reset rst_n. Reset values:
  - state=IDLE, lift_duty=0, thrust_duty=0, thrust target=0, steer_duty=STEER_CENTER(77).
  - led=0, cmd_err=0; tick prescaler and watchdog counters cleared.
  - Reset asserted mid-ramp aborts immediately to these values.
- Tick: the prescaler counts 0..TICK_CYCLES-1 and pulses tick for one cycle at wrap.
- Command decode, on rx_valid only; byte 0x00 is ignored:
  - [7:6]=00, system: 0x01 ARM, 0x02 DISARM, 0x03 ESTOP; any other value gives cmd_err.
  - [7:6]=01, thrust: target = level[5:0]<<4 (0..1008).
  - [7:6]=10, steer: steer_duty = 51 + min(level,51), range 51..102.
  - [7:6]=11: cmd_err (see Optional Feature).
- Latency: a command at cycle N is visible in state, targets and steer_duty at N+1.
- Command acceptance by state:
  - Thrust commands are accepted only in RUN, and ignored elsewhere with no error.
  - Steer commands are accepted in every state except FAULT.
- FSM:
  - IDLE: ARM -> SPINUP.
  - SPINUP: lift slews toward LIFT_DUTY with thrust held at 0. Lift == LIFT_DUTY -> RUN. DISARM or watchdog -> STOP.
  - RUN: thrust slews toward its target and lift is held. DISARM or watchdog -> STOP, and the target is cleared to 0.
  - STOP: lift and thrust both slew toward 0. Both == 0 -> IDLE. ARM is ignored.
  - FAULT: all duties 0 in the cycle after ESTOP and steer forced to 77. Only DISARM exits, to IDLE.
  - ESTOP from any state -> FAULT.
- Slew, on tick only: if |target-cur| <= RAMP_STEP then cur = target, otherwise cur moves by RAMP_STEP toward target. It never overshoots, and there is no wrap (no 10-bit overflow).
- Watchdog:
  - Counts ticks in SPINUP and RUN, and is held at 0 in other states.
  - Any rx_valid clears it, including a 0x00 byte.
  - Expires at TIMEOUT_TICKS.
- Same-cycle events:
  - ESTOP beats everything else.
  - rx_valid beats watchdog expiry in the same cycle.
  - A new target takes effect from the next tick; a tick in the same cycle slews toward the old target.
- State encoding: IDLE=0, SPINUP=1, RUN=2, STOP=3, FAULT=4.

Optional Feature:
- Macro: STEER_TRIM_EN.
- With the macro defined:
  - Opcode 11 is a trim command; [5:0] is signed two's-complement -32..31 and is stored in a trim register (reset 0).
  - steer_duty = clamp(base + trim, 51, 102); the FAULT centre is also 77 + trim, clamped.
  - No cmd_err is raised for opcode 11.
- Without the macro: opcode 11 gives cmd_err, and there is no trim register.

Decomposition:
- Package drive_seq_pkg holds:
  - state encoding;
  - opcode values and system command bytes (CMD_ARM=0x01, CMD_DISARM=0x02, CMD_ESTOP=0x03);
  - STEER_MIN=51, STEER_MAX=102, STEER_CENTER=77.
- Sub-module slew_limiter, instantiated twice (lift, thrust):
  - inputs: clk, rst_n, tick, target[9:0], step;
  - output: cur[9:0] (registered).

Test Plan (TICK_CYCLES=4, RAMP_STEP=64, LIFT_DUTY=768, TIMEOUT_TICKS=20):
- Reset, then ARM: state=1; lift rises 64 per tick, reaches 768 after 12 ticks; state=2 on the following cycle; led=1.
- In RUN, send 0x7F: thrust rises 0, 64, … 960 then 1008 after 16 ticks; send 0x40: thrust falls 64 per tick to 0.
- Send 0xBF -> steer_duty=102. Send 0x80 -> 51. Send 0x9A -> 77. Send 0xC5 with STEER_TRIM_EN off -> cmd_err pulses once and steer_duty is unchanged.
- In RUN with thrust=1008, send ESTOP: next cycle all duties 0, steer 77, state=4. ARM is ignored. DISARM -> state=0.
- In RUN, send no bytes for 20 ticks: state=3, both channels ramp to 0, then state=0. Repeat with a 0x00 byte at tick 19: stays in RUN.
- Send a thrust command in IDLE, then ARM: no thrust is applied after reaching RUN. Assert rst_n low mid-SPINUP: all outputs take their reset values immediately.
